// File: rtl/sensor_reg_sequencer.sv
// sensor_reg_sequencer
// Brings a camera sensor out of power-down and reset, then walks a register
// table held in an external synchronous ROM and drives an i2c_control master.
// Table entries are {op[1:0], addr, data}: WRITE, VERIFY (write then read
// back and compare), DELAY (data = milliseconds) and END.
// NACKed transactions are re-issued up to MAX_RETRY times per entry; a
// failing entry index is reported on err_index.
// The companion i2c master's address-mode input should be tied to
// (ADDR_W == 16).
module sensor_reg_sequencer #(
    parameter int SYS_CLOCK   = 50_000_000,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int ROM_AW      = 9,
    parameter int MAX_RETRY   = 3,
    parameter int RST_HOLD_MS = 1,
    parameter int CFG_WAIT_MS = 20,
    parameter bit AUTO_START  = 1'b1
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       start,
    output logic [ROM_AW-1:0]          rom_addr,
    input  logic [2+ADDR_W+DATA_W-1:0] rom_q,
    output logic                       i2c_wr_req,
    output logic                       i2c_rd_req,
    output logic [ADDR_W-1:0]          i2c_addr,
    output logic [DATA_W-1:0]          i2c_wdata,
    input  logic [DATA_W-1:0]          i2c_rdata,
    input  logic                       i2c_done,
    input  logic                       i2c_nack,
    output logic                       camera_pwdn,
    output logic                       camera_rst_n,
    output logic                       busy,
    output logic                       init_done,
    output logic                       init_err,
    output logic [ROM_AW-1:0]          err_index
);

    // Cycles per millisecond tick.
    localparam int TICK    = SYS_CLOCK / 1000;
    localparam int TICK_W  = (TICK > 1) ? $clog2(TICK) : 1;
    // Millisecond counter must hold the largest DELAY operand and the fixed waits.
    localparam int MS_W    = (DATA_W > 16) ? DATA_W : 16;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int ROM_W   = 2 + ADDR_W + DATA_W;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR,
        S_RST,
        S_CWAIT,
        S_FETCH,
        S_DECODE,
        S_WREQ,
        S_WWAIT,
        S_RREQ,
        S_RWAIT,
        S_DLY,
        S_DONE,
        S_ERR
    } state_e;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_VERIFY = 2'b01,
        OP_DELAY  = 2'b10,
        OP_END    = 2'b11
    } op_e;

    state_e               state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [MS_W-1:0]      ms_left;
    logic [RETRY_W-1:0]   retry_cnt;
    logic                 cur_verify;
    logic                 auto_pend;

    // Table entry fields as presented by the ROM during DECODE.
    logic [1:0]           rom_op;
    logic [ADDR_W-1:0]    rom_reg_addr;
    logic [DATA_W-1:0]    rom_reg_data;

    assign rom_op       = rom_q[ROM_W-1 -: 2];
    assign rom_reg_addr = rom_q[DATA_W +: ADDR_W];
    assign rom_reg_data = rom_q[DATA_W-1:0];

    // Millisecond timer: a timed state ends on the last cycle of its last ms.
    // A zero-length RST_HOLD_MS/CFG_WAIT_MS behaves as 1 ms.
    logic tick_end;
    logic ms_expire;

    assign tick_end  = (tick_cnt == TICK_W'(TICK - 1));
    assign ms_expire = tick_end && (ms_left <= MS_W'(1));

    // "Next entry": advance the table index, or finish on the last ROM slot (no wrap).
    logic                 last_entry;
    state_e               adv_state;
    logic [ROM_AW-1:0]    adv_addr;

    assign last_entry = &rom_addr;
    assign adv_state  = last_entry ? S_DONE : S_FETCH;
    assign adv_addr   = last_entry ? rom_addr : rom_addr + 1'b1;

    // Sequencer FSM with registered outputs and the shared ms timer.
    // NOTE: all state here is updated with non-blocking assignments so every
    // branch sees the pre-edge values; later assignments in the same cycle
    // (e.g. a timer reload on state entry) intentionally override the defaults.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= S_IDLE;
            tick_cnt     <= '0;
            ms_left      <= '0;
            retry_cnt    <= '0;
            cur_verify   <= 1'b0;
            auto_pend    <= AUTO_START;
            rom_addr     <= '0;
            i2c_wr_req   <= 1'b0;
            i2c_rd_req   <= 1'b0;
            i2c_addr     <= '0;
            i2c_wdata    <= '0;
            camera_pwdn  <= 1'b1;
            camera_rst_n <= 1'b0;
            busy         <= 1'b0;
            init_done    <= 1'b0;
            init_err     <= 1'b0;
            err_index    <= '0;
        end else begin
            i2c_wr_req <= 1'b0;
            i2c_rd_req <= 1'b0;
            auto_pend  <= 1'b0;

            if (tick_end) begin
                tick_cnt <= '0;
                ms_left  <= ms_left - 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start || auto_pend) begin
                        init_done    <= 1'b0;
                        init_err     <= 1'b0;
                        err_index    <= '0;
                        camera_pwdn  <= 1'b1;
                        camera_rst_n <= 1'b0;
                        rom_addr     <= '0;
                        busy         <= 1'b1;
                        tick_cnt     <= '0;
                        ms_left      <= MS_W'(1);
                        state        <= S_PWR;
                    end
                end

                S_PWR: begin
                    camera_pwdn <= 1'b0;
                    if (ms_expire) begin
                        tick_cnt <= '0;
                        ms_left  <= MS_W'(RST_HOLD_MS);
                        state    <= S_RST;
                    end
                end

                S_RST: begin
                    if (ms_expire) begin
                        camera_rst_n <= 1'b1;
                        tick_cnt     <= '0;
                        ms_left      <= MS_W'(CFG_WAIT_MS);
                        state        <= S_CWAIT;
                    end
                end

                S_CWAIT: begin
                    if (ms_expire) begin
                        state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    retry_cnt <= '0;
                    state     <= S_DECODE;
                end

                S_DECODE: begin
                    i2c_addr   <= rom_reg_addr;
                    i2c_wdata  <= rom_reg_data;
                    cur_verify <= (op_e'(rom_op) == OP_VERIFY);
                    case (op_e'(rom_op))
                        OP_WRITE, OP_VERIFY: begin
                            i2c_wr_req <= 1'b1;
                            state      <= S_WREQ;
                        end
                        OP_DELAY: begin
                            if (rom_reg_data == '0) begin
                                rom_addr <= adv_addr;
                                state    <= adv_state;
                            end else begin
                                tick_cnt <= '0;
                                ms_left  <= MS_W'(rom_reg_data);
                                state    <= S_DLY;
                            end
                        end
                        default: state <= S_DONE;
                    endcase
                end

                S_WREQ: state <= S_WWAIT;

                S_WWAIT: begin
                    if (i2c_done) begin
                        if (i2c_nack) begin
                            if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
                                state <= S_ERR;
                            end else begin
                                retry_cnt  <= retry_cnt + 1'b1;
                                i2c_wr_req <= 1'b1;
                                state      <= S_WREQ;
                            end
                        end else if (cur_verify) begin
                            i2c_rd_req <= 1'b1;
                            state      <= S_RREQ;
                        end else begin
                            rom_addr <= adv_addr;
                            state    <= adv_state;
                        end
                    end
                end

                S_RREQ: state <= S_RWAIT;

                S_RWAIT: begin
                    if (i2c_done) begin
                        if (i2c_nack) begin
                            if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
                                state <= S_ERR;
                            end else begin
                                retry_cnt  <= retry_cnt + 1'b1;
                                i2c_rd_req <= 1'b1;
                                state      <= S_RREQ;
                            end
                        end else if (i2c_rdata != i2c_wdata) begin
                            state <= S_ERR;
                        end else begin
                            rom_addr <= adv_addr;
                            state    <= adv_state;
                        end
                    end
                end

                S_DLY: begin
                    if (ms_expire) begin
                        rom_addr <= adv_addr;
                        state    <= adv_state;
                    end
                end

                S_DONE: begin
                    init_done <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                S_ERR: begin
                    init_err  <= 1'b1;
                    err_index <= rom_addr;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_reg_sequencer.sv
// tb_sensor_reg_sequencer
// Scoreboarded bench: a table-level reference model predicts the i2c request
// stream and final status; a monitor pops and compares every request; a
// behavioural i2c slave answers with programmable NACKs and readback data.
module tb_sensor_reg_sequencer;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int ROM_AW    = 4;
    localparam int DEPTH     = 1 << ROM_AW;
    localparam int MAX_RETRY = 3;
    localparam int RW        = 2 + ADDR_W + DATA_W;

    localparam logic [1:0] OP_W = 2'b00, OP_V = 2'b01, OP_D = 2'b10, OP_E = 2'b11;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic [RW-1:0]     rom_q;
    logic              i2c_wr_req, i2c_rd_req;
    logic [ADDR_W-1:0] i2c_addr;
    logic [DATA_W-1:0] i2c_wdata;
    logic [DATA_W-1:0] i2c_rdata;
    logic              i2c_done;
    logic              i2c_nack;
    logic              camera_pwdn, camera_rst_n;
    logic              busy, init_done, init_err;
    logic [ROM_AW-1:0] err_index;

    sensor_reg_sequencer #(
        .SYS_CLOCK(100_000), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_AW(ROM_AW),
        .MAX_RETRY(MAX_RETRY), .RST_HOLD_MS(1), .CFG_WAIT_MS(20), .AUTO_START(1'b1)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .start(start), .rom_addr(rom_addr), .rom_q(rom_q),
        .i2c_wr_req(i2c_wr_req), .i2c_rd_req(i2c_rd_req), .i2c_addr(i2c_addr),
        .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata), .i2c_done(i2c_done),
        .i2c_nack(i2c_nack), .camera_pwdn(camera_pwdn), .camera_rst_n(camera_rst_n),
        .busy(busy), .init_done(init_done), .init_err(init_err), .err_index(err_index)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Synchronous table ROM.
    logic [RW-1:0] rom [DEPTH];
    always @(posedge Clk) rom_q <= rom[rom_addr];

    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } txn_t;

    txn_t exp_q[$];
    int   req_cycles[$];
    int   done_cycles[$];
    bit   exp_done, exp_err;
    int   exp_idx;

    int checks = 0;
    int errors = 0;

    // Slave behaviour knobs.
    int          nack_addr = -1;
    int          nack_left = 0;
    int          bad_addr  = -1;
    logic [7:0]  bad_val   = 8'h00;
    int          reset_gen = 0;
    logic [7:0]  regmap [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [RW-1:0] ent(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
        return {op, a, d};
    endfunction

    // Reference model: walks the table as the sensor would see it.
    task automatic model_run();
        int         left;
        int         nacks;
        bit         failed;
        logic [1:0] op;
        logic [15:0] ea;
        logic [7:0]  ed;
        logic [7:0]  rv;
        left     = nack_left;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_idx  = 0;
        for (int i = 0; i < DEPTH; i++) begin
            op = rom[i][RW-1 -: 2];
            ea = rom[i][DATA_W +: ADDR_W];
            ed = rom[i][DATA_W-1:0];
            if (op == OP_E) begin
                exp_done = 1'b1;
                return;
            end
            if (op == OP_D) continue;
            nacks  = 0;
            failed = 1'b0;
            while (1) begin
                exp_q.push_back('{rd: 1'b0, a: ea, d: ed});
                if (int'(ea) == nack_addr && left > 0) begin
                    left--;
                    nacks++;
                    if (nacks > MAX_RETRY) begin
                        failed = 1'b1;
                        break;
                    end
                end else break;
            end
            if (!failed && op == OP_V) begin
                while (1) begin
                    exp_q.push_back('{rd: 1'b1, a: ea, d: ed});
                    if (int'(ea) == nack_addr && left > 0) begin
                        left--;
                        nacks++;
                        if (nacks > MAX_RETRY) begin
                            failed = 1'b1;
                            break;
                        end
                    end else break;
                end
                if (!failed) begin
                    rv = (int'(ea) == bad_addr) ? bad_val : ed;
                    if (rv != ed) failed = 1'b1;
                end
            end
            if (failed) begin
                exp_err = 1'b1;
                exp_idx = i;
                return;
            end
        end
        exp_done = 1'b1;
    endtask

    // Monitor: every request must match the head of the expected stream.
    always @(negedge Clk) begin
        txn_t t;
        if (Rst_n && (i2c_wr_req || i2c_rd_req)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: wr=%0b rd=%0b addr=0x%0h, expected no request",
                         i2c_wr_req, i2c_rd_req, i2c_addr);
            end else begin
                t = exp_q.pop_front();
                check("req_kind", {30'd0, i2c_rd_req, i2c_wr_req}, t.rd ? 32'd2 : 32'd1);
                check("req_addr", {16'd0, i2c_addr}, {16'd0, t.a});
                check("req_data", {24'd0, i2c_wdata}, {24'd0, t.d});
            end
            req_cycles.push_back(cyc);
        end
    end

    // Edge recorders for sensor power/reset pins.
    logic prev_pwdn = 1'b1, prev_rst = 1'b0;
    int   pwdn_fall_cyc = 0, rst_rise_cyc = 0;
    always @(negedge Clk) begin
        if (prev_pwdn && !camera_pwdn) pwdn_fall_cyc <= cyc;
        if (!prev_rst && camera_rst_n) rst_rise_cyc <= cyc;
        prev_pwdn <= camera_pwdn;
        prev_rst  <= camera_rst_n;
    end

    // Behavioural i2c slave: random latency, programmable NACKs and bad readback.
    initial begin
        bit          s_rd, s_nack;
        logic [15:0] s_a;
        logic [7:0]  s_d;
        int          s_gen;
        i2c_done  = 1'b0;
        i2c_nack  = 1'b0;
        i2c_rdata = '0;
        forever begin
            @(negedge Clk);
            if (Rst_n && (i2c_wr_req || i2c_rd_req)) begin
                s_rd  = i2c_rd_req;
                s_a   = i2c_addr;
                s_d   = i2c_wdata;
                s_gen = reset_gen;
                repeat ($urandom_range(1, 4)) @(posedge Clk);
                #1;
                if (s_gen == reset_gen && Rst_n) begin
                    s_nack = (int'(s_a) == nack_addr && nack_left > 0);
                    if (s_nack) nack_left--;
                    if (!s_nack && !s_rd) regmap[int'(s_a)] = s_d;
                    if (s_rd)
                        i2c_rdata = (int'(s_a) == bad_addr) ? bad_val :
                                    (regmap.exists(int'(s_a)) ? regmap[int'(s_a)] : 8'h00);
                    else
                        i2c_rdata = 8'h00;
                    i2c_nack = s_nack;
                    i2c_done = 1'b1;
                    done_cycles.push_back(cyc);
                    @(posedge Clk);
                    #1;
                    i2c_done = 1'b0;
                    i2c_nack = 1'b0;
                end
            end
        end
    end

    task automatic fill_end();
        for (int i = 0; i < DEPTH; i++) rom[i] = ent(OP_E, 16'h0, 8'h0);
    endtask

    task automatic setup(input int na, input int nn, input int ba, input logic [7:0] bv);
        nack_addr = na;
        nack_left = nn;
        bad_addr  = ba;
        bad_val   = bv;
        exp_q.delete();
        req_cycles.delete();
        done_cycles.delete();
        model_run();
    endtask

    task automatic pulse_start();
        @(posedge Clk);
        #1 start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pwdn"},      {31'd0, camera_pwdn},  32'd1);
        check({tag, "_rst_n"},     {31'd0, camera_rst_n}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy},         32'd0);
        check({tag, "_done"},      {31'd0, init_done},    32'd0);
        check({tag, "_err"},       {31'd0, init_err},     32'd0);
        check({tag, "_req"},       {30'd0, i2c_rd_req, i2c_wr_req}, 32'd0);
        check({tag, "_rom_addr"},  {28'd0, rom_addr},     32'd0);
        check({tag, "_err_index"}, {28'd0, err_index},    32'd0);
    endtask

    // Waits for the run to finish and compares the final status against the model.
    task automatic finish_run(input string tag);
        int n;
        n = 0;
        while (!busy && n < 8) begin
            @(negedge Clk);
            n++;
        end
        check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 20000) begin
            @(negedge Clk);
            n++;
        end
        check({tag, "_finished"}, {31'd0, busy}, 32'd0);
        repeat (60) @(negedge Clk);
        check({tag, "_init_done"}, {31'd0, init_done}, {31'd0, exp_done});
        check({tag, "_init_err"},  {31'd0, init_err},  {31'd0, exp_err});
        if (exp_err) check({tag, "_err_index"}, {28'd0, err_index}, exp_idx);
        check({tag, "_flags_exclusive"}, {31'd0, init_done & init_err}, 32'd0);
        check({tag, "_sb_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, n, len, k;
        logic [1:0] op;

        // Reset values.
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_reset_vals("reset");

        // A: auto start, power timing, delay gap.
        fill_end();
        rom[0] = ent(OP_W, 16'h3008, 8'h82);
        rom[1] = ent(OP_D, 16'h0000, 8'd5);
        rom[2] = ent(OP_W, 16'h3103, 8'h03);
        setup(-1, 0, -1, 8'h00);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        rel = cyc;
        finish_run("auto");
        check_range("pwdn_fall", pwdn_fall_cyc - rel, 1, 3);
        check_range("rst_n_rise", rst_rise_cyc - rel, 195, 205);
        check("auto_req_count", req_cycles.size(), 32'd2);
        if (req_cycles.size() == 2 && done_cycles.size() >= 1) begin
            check_range("first_wr_req", req_cycles[0] - rel, 2195, 2210);
            check_range("delay_gap", req_cycles[1] - done_cycles[0], 500, 510);
        end

        // B: entry 2 NACKed three times then acked.
        rom[1] = ent(OP_D, 16'h0000, 8'd0);
        setup(16'h3103, 3, -1, 8'h00);
        pulse_start();
        finish_run("nack3");
        check("nack3_req_count", req_cycles.size(), 32'd5);

        // C: entry 2 always NACKed.
        setup(16'h3103, 1000, -1, 8'h00);
        pulse_start();
        finish_run("nack_all");
        check("nack_all_req_count", req_cycles.size(), 32'd5);
        check("nack_all_err_index", {28'd0, err_index}, 32'd2);

        // D: verify passes.
        fill_end();
        rom[0] = ent(OP_W, 16'h1234, 8'hAA);
        rom[1] = ent(OP_V, 16'h300E, 8'h58);
        setup(-1, 0, -1, 8'h00);
        pulse_start();
        finish_run("verify_ok");
        check("verify_ok_req_count", req_cycles.size(), 32'd3);

        // E: verify readback mismatch, no retry of the read.
        setup(-1, 0, 16'h300E, 8'h18);
        pulse_start();
        finish_run("verify_bad");
        check("verify_bad_req_count", req_cycles.size(), 32'd3);
        check("verify_bad_err_index", {28'd0, err_index}, 32'd1);

        // H: reset while waiting for i2c_done, then starts while busy.
        fill_end();
        rom[0] = ent(OP_W, 16'h3008, 8'h82);
        rom[1] = ent(OP_W, 16'h3103, 8'h03);
        setup(-1, 0, -1, 8'h00);
        pulse_start();
        n = 0;
        while (req_cycles.size() == 0 && n < 5000) begin
            @(negedge Clk);
            n++;
        end
        check("midrun_req_seen", req_cycles.size(), 32'd1);
        @(posedge Clk);
        #1 Rst_n = 1'b0;
        reset_gen++;
        #1;
        check_reset_vals("midrun_reset");
        pulse_start();
        @(negedge Clk);
        check_reset_vals("start_in_reset");
        setup(-1, 0, -1, 8'h00);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        rel = cyc;
        repeat (50) @(posedge Clk);
        pulse_start();
        n = 0;
        while (req_cycles.size() == 0 && n < 5000) begin
            @(negedge Clk);
            n++;
        end
        pulse_start();
        finish_run("busy_start");
        check_range("busy_start_rst_rise", rst_rise_cyc - rel, 195, 205);
        check("busy_start_req_count", req_cycles.size(), 32'd2);

        // F: table with no END runs to the last slot and stops there.
        for (int i = 0; i < DEPTH; i++) rom[i] = ent(OP_W, 16'h4000 + 16'(i), 8'(i * 7));
        setup(-1, 0, -1, 8'h00);
        pulse_start();
        finish_run("table_end");
        check("table_end_req_count", req_cycles.size(), DEPTH);
        check("table_end_rom_addr", {28'd0, rom_addr}, DEPTH - 1);

        // G: randomized tables against the reference model.
        for (int r = 0; r < 5; r++) begin
            fill_end();
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                op = 2'($urandom_range(0, 2));
                rom[i] = ent(op, 16'($urandom), (op == OP_D) ? 8'($urandom_range(0, 2)) : 8'($urandom));
            end
            k = $urandom_range(0, len - 1);
            if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(0, len - 1);
                setup(int'(rom[k][DATA_W +: ADDR_W]), $urandom_range(0, 5),
                      int'(rom[n][DATA_W +: ADDR_W]), 8'($urandom));
            end else begin
                setup(int'(rom[k][DATA_W +: ADDR_W]), $urandom_range(0, 5), -1, 8'h00);
            end
            pulse_start();
            finish_run("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
